// File: rtl/decode_in_stim_engine_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : decode_in_pkg_hdl                                            |
// | Description : Shared types and default widths for the decode-input         |
// |               stimulus engine (entry layout, issue-state encoding).        |
// |               Optional feature macro: DECODE_IN_STIM_GAP_EN                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package decode_in_pkg_hdl;

  localparam int DEF_INSTR_W = 16;
  localparam int DEF_NPC_W   = 16;
  localparam int DEF_PSR_W   = 3;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_GAP_W   = 4;

  // Issue engine states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GAP   = 2'd1,
    ISSUE = 2'd2
  } stim_state_e;

  // One queued decode-input transaction at the default widths
  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_NPC_W-1:0]   npc;
    logic [DEF_PSR_W-1:0]   psr;
    logic                   enable;
    logic [DEF_GAP_W-1:0]   gap;
  } stim_entry_t;

  // Width of an occupancy counter that must reach DEPTH itself
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_in_stim_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : decode_in_stim_engine_if                                     |
// | Description : Push side, control and decode-bus signals of the stimulus    |
// |               engine. master = driver proxy / bench, slave = engine.       |
// |               Optional feature macro: DECODE_IN_STIM_GAP_EN                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface decode_in_stim_engine_if
  import decode_in_pkg_hdl::*;
#(
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int NPC_W   = DEF_NPC_W,
  parameter int PSR_W   = DEF_PSR_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int GAP_W   = DEF_GAP_W
) ();

  localparam int LVL_W = lvl_w(DEPTH);

  logic               initiator_en;
  logic               push_valid;
  logic               push_ready;
  logic [INSTR_W-1:0] push_instr;
  logic [NPC_W-1:0]   push_npc;
  logic [PSR_W-1:0]   push_psr;
  logic               push_enable;
  logic [GAP_W-1:0]   push_gap;
  logic               hold;
  logic               flush;
  logic               enable_decode;
  logic [INSTR_W-1:0] instr_dout;
  logic [NPC_W-1:0]   npc_in;
  logic [PSR_W-1:0]   psr;
  logic               bus_oe;
  logic [LVL_W-1:0]   level;
  logic [15:0]        issued_count;
  logic               busy;

  modport master (
    output initiator_en, push_valid, push_instr, push_npc, push_psr,
           push_enable, push_gap, hold, flush,
    input  push_ready, enable_decode, instr_dout, npc_in, psr, bus_oe,
           level, issued_count, busy
  );

  modport slave (
    input  initiator_en, push_valid, push_instr, push_npc, push_psr,
           push_enable, push_gap, hold, flush,
    output push_ready, enable_decode, instr_dout, npc_in, psr, bus_oe,
           level, issued_count, busy
  );

endinterface
`default_nettype wire

// File: rtl/decode_in_stim_engine_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : decode_in_stim_fifo                                          |
// | Description : Synchronous DEPTH x WIDTH FIFO with show-ahead head output,  |
// |               occupancy level and a single-cycle flush.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module decode_in_stim_fifo
  import decode_in_pkg_hdl::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = DEF_DEPTH,
  parameter int LVL_W = lvl_w(DEPTH)
) (
  input  wire              clock,
  input  wire              reset,
  input  wire              flush,
  input  wire              push,
  input  wire  [WIDTH-1:0] push_data,
  input  wire              pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Flush wins over both sides; overflow/underflow requests are dropped here
  assign do_push = push & ~full  & ~flush;
  assign do_pop  = pop  & ~empty & ~flush;

  assign full  = (count == LVL_W'(DEPTH));
  assign empty = (count == '0);
  assign level = count;
  assign head  = mem[rd_ptr];

  // Storage array: written on accepted pushes only, never reset
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/decode_in_stim_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : decode_in_stim_engine                                        |
// | Description : Queues LC3 decode-input transactions and plays them onto the |
// |               decode inputs one per clock, with optional idle gaps, hold   |
// |               and flush.                                                   |
// |               Optional feature macro: DECODE_IN_STIM_GAP_EN (per-entry     |
// |               idle gap; when undefined every entry issues back-to-back).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module decode_in_stim_engine
  import decode_in_pkg_hdl::*;
#(
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int NPC_W   = DEF_NPC_W,
  parameter int PSR_W   = DEF_PSR_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int GAP_W   = DEF_GAP_W
) (
  input wire clock,
  input wire reset,
  decode_in_stim_engine_if.slave bus
);

  localparam int LVL_W = lvl_w(DEPTH);
`ifdef DECODE_IN_STIM_GAP_EN
  localparam int ENTRY_W = INSTR_W + NPC_W + PSR_W + 1 + GAP_W;
`else
  localparam int ENTRY_W = INSTR_W + NPC_W + PSR_W + 1;
`endif

  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [LVL_W-1:0]   level;

  logic [INSTR_W-1:0] head_instr;
  logic [NPC_W-1:0]   head_npc;
  logic [PSR_W-1:0]   head_psr;
  logic               head_enable;

  stim_state_e        state;
  stim_state_e        state_n;
  logic               issue;
  logic               enable_n;

  logic               enable_r;
  logic [INSTR_W-1:0] instr_r;
  logic [NPC_W-1:0]   npc_r;
  logic [PSR_W-1:0]   psr_r;
  logic [15:0]        issued_r;

`ifdef DECODE_IN_STIM_GAP_EN
  logic [GAP_W-1:0]   head_gap;
  logic [GAP_W-1:0]   gap_cnt;
  logic [GAP_W-1:0]   gap_cnt_n;

  assign push_data = {bus.push_instr, bus.push_npc, bus.push_psr,
                      bus.push_enable, bus.push_gap};
  assign {head_instr, head_npc, head_psr, head_enable, head_gap} = head;
`else
  // The gap field is neither stored nor looked at in this build
  logic [GAP_W-1:0]   unused_gap;

  assign unused_gap = bus.push_gap;
  assign push_data  = {bus.push_instr, bus.push_npc, bus.push_psr,
                       bus.push_enable};
  assign {head_instr, head_npc, head_psr, head_enable} = head;
`endif

  // No bypass: a pushed entry is always visible to the engine one edge later
  assign bus.push_ready = ~full & ~bus.flush;
  assign push           = bus.push_valid & bus.push_ready;

  decode_in_stim_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (bus.flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // Next-state, pop and issue decision; flush beats hold, hold freezes all
  always_comb begin
    state_n  = state;
    pop      = 1'b0;
    issue    = 1'b0;
    enable_n = enable_r;
`ifdef DECODE_IN_STIM_GAP_EN
    gap_cnt_n = gap_cnt;
`endif
    if (bus.flush) begin
      state_n  = IDLE;
      enable_n = 1'b0;
`ifdef DECODE_IN_STIM_GAP_EN
      gap_cnt_n = '0;
`endif
    end else if (!bus.hold) begin
      enable_n = 1'b0;
      case (state)
        IDLE, ISSUE: begin
          state_n = IDLE;
          if (!empty) begin
`ifdef DECODE_IN_STIM_GAP_EN
            if (head_gap == '0) begin
              pop      = 1'b1;
              issue    = 1'b1;
              enable_n = head_enable;
              state_n  = ISSUE;
            end else begin
              gap_cnt_n = head_gap - 1'b1;
              state_n   = GAP;
            end
`else
            pop      = 1'b1;
            issue    = 1'b1;
            enable_n = head_enable;
            state_n  = ISSUE;
`endif
          end
        end
        GAP: begin
`ifdef DECODE_IN_STIM_GAP_EN
          if (gap_cnt == '0) begin
            pop      = 1'b1;
            issue    = 1'b1;
            enable_n = head_enable;
            state_n  = ISSUE;
          end else begin
            gap_cnt_n = gap_cnt - 1'b1;
          end
`else
          state_n = IDLE;
`endif
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State register (and gap countdown when gaps are built in)
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
`ifdef DECODE_IN_STIM_GAP_EN
      gap_cnt <= '0;
`endif
    end else begin
      state <= state_n;
`ifdef DECODE_IN_STIM_GAP_EN
      gap_cnt <= gap_cnt_n;
`endif
    end
  end

  // Decode-bus output registers; data fields hold between issues
  always_ff @(posedge clock) begin
    if (reset) begin
      enable_r <= 1'b0;
      instr_r  <= '0;
      npc_r    <= '0;
      psr_r    <= '0;
      issued_r <= '0;
    end else begin
      enable_r <= enable_n;
      if (issue) begin
        instr_r  <= head_instr;
        npc_r    <= head_npc;
        psr_r    <= head_psr;
        issued_r <= issued_r + 16'd1;
      end
    end
  end

  assign bus.enable_decode = enable_r;
  assign bus.instr_dout    = instr_r;
  assign bus.npc_in        = npc_r;
  assign bus.psr           = psr_r;
  assign bus.bus_oe        = bus.initiator_en;
  assign bus.level         = level;
  assign bus.issued_count  = issued_r;
  assign bus.busy          = (level != '0) | (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_decode_in_stim_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_decode_in_stim_engine                                     |
// | Description : Self-checking bench for decode_in_stim_engine. A queue model |
// |               schedules every accepted entry's issue edge arithmetically.  |
// |               Honours DECODE_IN_STIM_GAP_EN when defined.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_decode_in_stim_engine;
  import decode_in_pkg_hdl::*;

  localparam int INSTR_W = 16;
  localparam int NPC_W   = 16;
  localparam int PSR_W   = 3;
  localparam int DEPTH   = 8;
  localparam int GAP_W   = 4;
  localparam int FAR     = 1 << 30;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  decode_in_stim_engine_if #(
    .INSTR_W(INSTR_W), .NPC_W(NPC_W), .PSR_W(PSR_W), .DEPTH(DEPTH), .GAP_W(GAP_W)
  ) bus ();

  decode_in_stim_engine #(
    .INSTR_W(INSTR_W), .NPC_W(NPC_W), .PSR_W(PSR_W), .DEPTH(DEPTH), .GAP_W(GAP_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] instr;
    logic [15:0] npc;
    logic [2:0]  psr;
    logic        en;
    int          gap;
    int          t;
  } exp_t;

  exp_t        q[$];
  int          cyc, checks, passes, fails;
  int          t_last_sched, t_last_issue;
  logic [15:0] last_instr, last_npc, issued_exp;
  logic [2:0]  last_psr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  // Edge on which an entry is issued: it is inspected one edge after it was
  // accepted or one edge after its predecessor issued, whichever is later,
  // then waits out its gap.
  function automatic int sched(input int p, input int g);
    int d;
    d = (p + 1 > t_last_sched + 1) ? p + 1 : t_last_sched + 1;
    return d + g;
  endfunction

  task automatic step(input logic v, input logic [15:0] instr, input logic [15:0] npc,
                      input logic [2:0] psr, input logic en, input int gap);
    logic ready_exp, acc;
    exp_t e;
    bus.push_valid  = v;
    bus.push_instr  = instr;
    bus.push_npc    = npc;
    bus.push_psr    = psr;
    bus.push_enable = en;
    bus.push_gap    = 4'(gap);
    #1;
    ready_exp = (q.size() < DEPTH) && !bus.flush;
    check("push_ready", {31'd0, bus.push_ready}, {31'd0, ready_exp});
    acc = v && ready_exp && !reset;
    @(posedge clock);
    #1;
    cyc++;
    if (reset || bus.flush) begin
      q.delete();
      t_last_sched = -10;
    end
    if (reset) begin
      issued_exp   = '0;
      last_instr   = '0;
      last_npc     = '0;
      last_psr     = '0;
      t_last_issue = -10;
    end
    if (acc) begin
      e.instr = instr;
      e.npc   = npc;
      e.psr   = psr;
      e.en    = en;
`ifdef DECODE_IN_STIM_GAP_EN
      e.gap   = gap;
`else
      e.gap   = 0;
`endif
      if (bus.hold) begin
        e.t = FAR;
      end else begin
        e.t = sched(cyc, e.gap);
        t_last_sched = e.t;
      end
      q.push_back(e);
    end
    if (q.size() > 0 && q[0].t == cyc) begin
      e = q.pop_front();
      issued_exp++;
      t_last_issue = cyc;
      check("issue enable_decode", {31'd0, bus.enable_decode}, {31'd0, e.en});
      check("issue instr_dout", {16'd0, bus.instr_dout}, {16'd0, e.instr});
      check("issue npc_in", {16'd0, bus.npc_in}, {16'd0, e.npc});
      check("issue psr", {29'd0, bus.psr}, {29'd0, e.psr});
      last_instr = e.instr;
      last_npc   = e.npc;
      last_psr   = e.psr;
    end else begin
      check("idle enable_decode", {31'd0, bus.enable_decode}, 32'd0);
      check("held instr_dout", {16'd0, bus.instr_dout}, {16'd0, last_instr});
      check("held npc_in", {16'd0, bus.npc_in}, {16'd0, last_npc});
      check("held psr", {29'd0, bus.psr}, {29'd0, last_psr});
    end
    check("issued_count", {16'd0, bus.issued_count}, {16'd0, issued_exp});
    check("level", {28'd0, bus.level}, q.size());
    check("busy", {31'd0, bus.busy}, {31'd0, (q.size() > 0) || (t_last_issue == cyc)});
    check("bus_oe", {31'd0, bus.bus_oe}, {31'd0, bus.initiator_en});
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'h0, 16'h0, 3'h0, 1'b0, 0);
  endtask

  // Dropping hold from an idle engine: queued entries are rescheduled as if
  // they had all been accepted on the current edge.
  task automatic release_hold();
    bus.hold     = 1'b0;
    t_last_sched = -10;
    foreach (q[i]) begin
      q[i].t       = sched(cyc, q[i].gap);
      t_last_sched = q[i].t;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; passes = 0; fails = 0; cyc = 0;
    t_last_sched = -10; t_last_issue = -10;
    issued_exp = '0; last_instr = '0; last_npc = '0; last_psr = '0;

    // Reset held two edges with a push offered: nothing may be captured
    reset            = 1'b1;
    bus.initiator_en = 1'b1;
    bus.hold         = 1'b0;
    bus.flush        = 1'b0;
    bus.push_valid   = 1'b1;
    bus.push_instr   = 16'hDEAD;
    bus.push_npc     = 16'hBEEF;
    bus.push_psr     = 3'h7;
    bus.push_enable  = 1'b1;
    bus.push_gap     = 4'h0;
    repeat (2) @(posedge clock);
    #1;
    cyc = 2;
    check("rst enable_decode", {31'd0, bus.enable_decode}, 32'd0);
    check("rst instr_dout", {16'd0, bus.instr_dout}, 32'd0);
    check("rst npc_in", {16'd0, bus.npc_in}, 32'd0);
    check("rst psr", {29'd0, bus.psr}, 32'd0);
    check("rst level", {28'd0, bus.level}, 32'd0);
    check("rst push_ready", {31'd0, bus.push_ready}, 32'd1);
    check("rst issued_count", {16'd0, bus.issued_count}, 32'd0);
    check("rst busy", {31'd0, bus.busy}, 32'd0);
    reset = 1'b0;
    idle(2);

    // Back-to-back issue of three entries
    step(1'b1, 16'h1234, 16'h3001, 3'd1, 1'b1, 0);
    step(1'b1, 16'h5678, 16'h3002, 3'd2, 1'b1, 0);
    step(1'b1, 16'h9ABC, 16'h3003, 3'd4, 1'b1, 0);
    idle(3);
    check("b2b issued_count", {16'd0, bus.issued_count}, 32'd3);
    check("b2b last instr", {16'd0, bus.instr_dout}, 32'h9ABC);

    // Single entry with a gap of three
    step(1'b1, 16'h0F00, 16'h3010, 3'd2, 1'b1, 3);
    idle(6);
    check("gap instr", {16'd0, bus.instr_dout}, 32'h0F00);

    // Responder mode: bus not driven but the queue still issues
    bus.initiator_en = 1'b0;
    step(1'b1, 16'h4444, 16'h3020, 3'd1, 1'b0, 0);
    check("resp bus_oe", {31'd0, bus.bus_oe}, 32'd0);
    idle(2);
    check("resp issued_count", {16'd0, bus.issued_count}, 32'd5);
    bus.initiator_en = 1'b1;

    // Fill under hold: ninth push refused, then drain eight back-to-back
    bus.hold = 1'b1;
    for (int i = 0; i < 9; i++) step(1'b1, 16'h7000 + 16'(i), 16'h3100 + 16'(i), 3'(i), 1'b1, 0);
    check("full level", {28'd0, bus.level}, 32'd8);
    check("full push_ready", {31'd0, bus.push_ready}, 32'd0);
    release_hold();
    idle(10);
    check("drain issued_count", {16'd0, bus.issued_count}, 32'd13);

    // Flush after two of five queued entries have issued
    bus.hold = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 16'h8000 + 16'(i), 16'h3200 + 16'(i), 3'(i), 1'b1, 0);
    release_hold();
    idle(2);
    bus.flush = 1'b1;
    idle(1);
    bus.flush = 1'b0;
    check("flush level", {28'd0, bus.level}, 32'd0);
    idle(4);
    check("flush issued_count", {16'd0, bus.issued_count}, 32'd15);

    // Randomized traffic with random gaps and responder toggling
    for (int i = 0; i < 300; i++) begin
      bus.initiator_en = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 3'($urandom),
           1'($urandom), int'($urandom_range(0, 3)));
    end
    bus.initiator_en = 1'b1;
    idle(40);

    // Reset while entries are queued and one is in flight
    step(1'b1, 16'hA001, 16'h3300, 3'd1, 1'b1, 2);
    step(1'b1, 16'hA002, 16'h3301, 3'd2, 1'b1, 0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("mid-reset issued_count", {16'd0, bus.issued_count}, 32'd0);
    check("mid-reset instr_dout", {16'd0, bus.instr_dout}, 32'd0);
    idle(4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
